// File: rtl/a2_chan_sched.sv
// a2_chan_sched: once per frame, walks every ADPCM channel, pushes the stored A2
// coefficient through the shared UPA2 datapath, limits the result and writes it back.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   frame_start            one-cycle pulse that starts a pass over all channels
//   busy, frame_done       pass in progress / one-cycle end-of-pass pulse
//   ch                     channel currently being processed
//   mem_rd, mem_addr       state RAM read strobe and address (address is ch)
//   mem_rdata              state RAM read data, valid the cycle after mem_rd
//   mem_wr, mem_wdata      state RAM write strobe and limited A2
//   dp_req, dp_gnt         request to / grant from the shared-resource arbiter
//   dp_a2                  A2 operand presented to the datapath
//   dp_valid, dp_result    datapath result strobe and unlimited A2T
//   clip_cnt               channels clipped in the current/last pass
//   dp_err                 sticky: a datapath result timed out
//   overrun                sticky: frame_start arrived while a pass was running
module a2_chan_sched #(
  parameter int unsigned NCH  = 32,
  parameter int unsigned CHW  = 5,
  parameter int unsigned TMO  = 15,
  parameter logic [15:0] A2UL = 16'h3000,
  parameter logic [15:0] A2LL = 16'hD000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_start,
  output logic           busy,
  output logic           frame_done,
  output logic [CHW-1:0] ch,
  output logic           mem_rd,
  output logic [CHW-1:0] mem_addr,
  input  logic [15:0]    mem_rdata,
  output logic           mem_wr,
  output logic [15:0]    mem_wdata,
  output logic           dp_req,
  input  logic           dp_gnt,
  output logic [15:0]    dp_a2,
  input  logic           dp_valid,
  input  logic [15:0]    dp_result,
  output logic [CHW:0]   clip_cnt,
  output logic           dp_err,
  output logic           overrun
);

  // Timer runs 0..TMO-1 while waiting; the last value is the final cycle dp_valid is accepted.
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0]  TmoLast = TW'(TMO - 1);
  localparam logic [CHW-1:0] LastCh  = CHW'(NCH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StReq,
    StWaitDp,
    StWrite,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [15:0]    op_q, op_d;
  logic [15:0]    val_q, val_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [CHW:0]   clip_q, clip_d;
  logic           err_q, err_d;
  logic           ovr_q, ovr_d;
  logic [15:0]    limited;

  // Unsigned compares: [0x8000, A2LL] is the too-negative range, [A2UL, 0x7FFF] too positive.
  function automatic logic [15:0] a2_limit(input logic [15:0] x);
    if (x[15] && (x <= A2LL)) begin
      return A2LL;
    end else if (!x[15] && (x >= A2UL)) begin
      return A2UL;
    end else begin
      return x;
    end
  endfunction

  assign limited = a2_limit(val_q);

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      op_q    <= '0;
      val_q   <= '0;
      timer_q <= '0;
      clip_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      op_q    <= op_d;
      val_q   <= val_d;
      timer_q <= timer_d;
      clip_q  <= clip_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (frame_start) state_d = StRead;
      StRead:   state_d = StLoad;
      StLoad:   state_d = StReq;
      StReq:    if (dp_gnt) state_d = StWaitDp;
      StWaitDp: if (dp_valid || (timer_q == TmoLast)) state_d = StWrite;
      StWrite:  state_d = (ch_q == LastCh) ? StDone : StRead;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state logic.
  always_comb begin
    ch_d    = ch_q;
    op_d    = op_q;
    val_d   = val_q;
    timer_d = timer_q;
    clip_d  = clip_q;
    err_d   = err_q;
    // Any frame_start outside IDLE (DONE included) is dropped and flagged.
    ovr_d   = ovr_q | (frame_start && (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          ch_d   = '0;
          clip_d = '0;
        end
      end
      StLoad: op_d = mem_rdata;
      StReq: begin
        if (dp_gnt) timer_d = '0;
      end
      StWaitDp: begin
        if (dp_valid) begin
          val_d = dp_result;
        end else if (timer_q == TmoLast) begin
          // Timed out: write the original coefficient back, limited as usual.
          val_d = op_q;
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWrite: begin
        if (limited != val_q) clip_d = clip_q + 1'b1;
        if (ch_q != LastCh) ch_d = ch_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from registered state, so reset clears them immediately.
  always_comb begin
    busy       = (state_q != StIdle);
    frame_done = (state_q == StDone);
    mem_rd     = (state_q == StRead);
    mem_wr     = (state_q == StWrite);
    dp_req     = (state_q == StReq);
    mem_wdata  = (state_q == StWrite) ? limited : 16'h0000;
    ch         = ch_q;
    mem_addr   = ch_q;
    dp_a2      = op_q;
    clip_cnt   = clip_q;
    dp_err     = err_q;
    overrun    = ovr_q;
  end

endmodule
